// File: rtl/fetch_mem_arbiter.sv
// Shares one variable-latency SRAM between IF and MEM; MEM wins unless IF has waited MEM_BURST_MAX grants.
// Round trip is grant N, sram_req N+1..ack M, ready M+1; each port is stalled through its freeze output.
module fetch_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              freeze_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              freeze_mem,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_DRAIN = 2'd3
    } state_e;

    localparam int              CNT_W     = $clog2(MEM_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MEM_BURST_MAX);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic if_elig, mem_elig, grant_if, grant_mem;

    // A request is not eligible in its own completion cycle, so a held req is never re-granted.
    assign if_elig  = if_req & ~if_ready_q & ~if_flush;
    assign mem_elig = mem_req & ~mem_ready_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        grant_if     = 1'b0;
        grant_mem    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_elig && (!if_elig || (starve_cnt_q < BURST_MAX))) begin
                    grant_mem    = 1'b1;
                    state_d      = MEM_BUSY;
                    sram_req_d   = 1'b1;
                    sram_we_d    = mem_we;
                    sram_addr_d  = mem_addr;
                    sram_wdata_d = mem_wdata;
                end else if (if_elig) begin
                    grant_if    = 1'b1;
                    state_d     = IF_BUSY;
                    sram_req_d  = 1'b1;
                    sram_we_d   = 1'b0;
                    sram_addr_d = if_addr;
                end
            end
            IF_BUSY: begin
                if (sram_ack) begin
                    state_d    = IDLE;
                    sram_req_d = 1'b0;
                    if (!if_flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = sram_rdata;
                    end
                end else if (if_flush) begin
                    state_d = IF_DRAIN;
                end
            end
            IF_DRAIN: begin
                if (sram_ack) begin
                    state_d    = IDLE;
                    sram_req_d = 1'b0;
                end
            end
            MEM_BUSY: begin
                if (sram_ack) begin
                    state_d     = IDLE;
                    sram_req_d  = 1'b0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = sram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_mem && (starve_cnt_q < BURST_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign freeze_if  = if_req & ~if_ready_q & ~if_flush;
    assign freeze_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Random IF/MEM traffic against a transaction-level model of the arbiter and a behavioural SRAM.
module tb_fetch_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MBM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0, sram_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0, sram_rdata = '0;
    logic          if_ready, freeze_if, mem_ready, freeze_mem, sram_req, sram_we;
    logic [DW-1:0] if_rdata, mem_rdata, sram_wdata;
    logic [AW-1:0] sram_addr;

    always #5 clk = ~clk;

    fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BURST_MAX(MBM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata), .freeze_if(freeze_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .freeze_mem(freeze_mem),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ack(sram_ack)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] smem [logic [31:0]];

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Transaction-level view: who owns the SRAM, for what, and what each port should see next.
    bit          m_busy, m_owner_mem, m_we, m_drain, m_if_rdy, m_mem_rdy;
    int          m_starve;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;

    bit          n_if_req, n_if_flush, n_mem_req, n_mem_we, n_ack;
    logic [31:0] n_if_addr, n_mem_addr, n_mem_wdata, n_rdata;
    bit          s_seen;
    int          s_wait;

    task automatic model_reset();
        m_busy = 0; m_owner_mem = 0; m_we = 0; m_drain = 0; m_if_rdy = 0; m_mem_rdy = 0;
        m_starve = 0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
        n_if_req = 0; n_if_flush = 0; n_mem_req = 0; n_mem_we = 0; n_ack = 0;
        n_if_addr = '0; n_mem_addr = '0; n_mem_wdata = '0; n_rdata = '0;
        s_seen = 0; s_wait = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h100 + 32'($urandom_range(0, 7)) * 4;
    endfunction

    task automatic step();
        bit if_el, mem_el, g_if, g_mem, nx_if_rdy, nx_mem_rdy;
        check_val("if_ready", if_ready, m_if_rdy);
        check_val("mem_ready", mem_ready, m_mem_rdy);
        check_val("if_rdata", if_rdata, m_if_rdata);
        check_val("mem_rdata", mem_rdata, m_mem_rdata);
        check_val("freeze_if", freeze_if, if_req & ~m_if_rdy & ~if_flush);
        check_val("freeze_mem", freeze_mem, mem_req & ~m_mem_rdy);
        check_val("sram_req", sram_req, m_busy);
        if (m_busy) begin
            check_val("sram_addr", sram_addr, m_addr);
            check_val("sram_we", sram_we, m_we);
            if (m_we) check_val("sram_wdata", sram_wdata, m_wdata);
        end

        if_el = if_req && !m_if_rdy && !if_flush;
        mem_el = mem_req && !m_mem_rdy;
        g_if = 0; g_mem = 0; nx_if_rdy = 0; nx_mem_rdy = 0;
        if (!m_busy) begin
            if (mem_el && (!if_el || m_starve < MBM)) g_mem = 1;
            else if (if_el) g_if = 1;
        end
        if (!if_req || g_if) m_starve = 0;
        else if (g_mem && m_starve < MBM) m_starve++;

        if (m_busy) begin
            if (sram_ack) begin
                if (m_owner_mem) begin
                    nx_mem_rdy = 1;
                    m_mem_rdata = m_we ? sram_rdata : smem_rd(m_addr);
                end else if (!m_drain && !if_flush) begin
                    nx_if_rdy = 1;
                    m_if_rdata = smem_rd(m_addr);
                end
                m_busy = 0;
            end else if (!m_owner_mem && if_flush) begin
                m_drain = 1;
            end
        end
        if (g_mem) begin
            m_busy = 1; m_owner_mem = 1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_drain = 0;
        end
        if (g_if) begin
            m_busy = 1; m_owner_mem = 0; m_we = 0; m_addr = if_addr; m_drain = 0;
        end
        m_if_rdy = nx_if_rdy;
        m_mem_rdy = nx_mem_rdy;

        // SRAM: stores land on ack; latency is 1..5 cycles after the strobe rises; stray acks when idle.
        if (sram_ack && sram_req && sram_we) smem[sram_addr] = sram_wdata;
        if (sram_ack && sram_req) begin
            s_seen = 0; n_ack = 0;
        end else if (sram_req) begin
            if (!s_seen) begin s_seen = 1; s_wait = $urandom_range(0, 4); end
            if (s_wait == 0) n_ack = 1;
            else begin s_wait--; n_ack = 0; end
        end else begin
            s_seen = 0;
            n_ack = !g_if && !g_mem && ($urandom_range(0, 11) == 0);
        end
        n_rdata = (n_ack && sram_req && !sram_we) ? smem_rd(sram_addr) : $urandom;

        if (if_flush) begin
            n_if_flush = 0;
            n_if_req = ($urandom_range(0, 3) != 0);
            n_if_addr = rnd_addr();
        end else if (if_req && !if_ready) begin
            n_if_flush = ($urandom_range(0, 9) == 0) ||
                         (n_ack && m_busy && !m_owner_mem && $urandom_range(0, 2) == 0);
        end else begin
            n_if_flush = 0;
            n_if_req = ($urandom_range(0, 2) != 0);
            n_if_addr = rnd_addr();
        end
        if (!(mem_req && !mem_ready)) begin
            n_mem_req = ($urandom_range(0, 3) != 0);
            n_mem_we = $urandom_range(0, 1) == 1;
            n_mem_addr = rnd_addr();
            n_mem_wdata = $urandom;
        end
    endtask

    task automatic apply();
        if_req = n_if_req; if_addr = n_if_addr; if_flush = n_if_flush;
        mem_req = n_mem_req; mem_we = n_mem_we; mem_addr = n_mem_addr; mem_wdata = n_mem_wdata;
        sram_ack = n_ack; sram_rdata = n_rdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_sram_req"}, sram_req, 1'b0);
        check_val({tag, "_sram_we"}, sram_we, 1'b0);
        check_val({tag, "_sram_addr"}, sram_addr, 32'h0);
        check_val({tag, "_sram_wdata"}, sram_wdata, 32'h0);
        check_val({tag, "_if_ready"}, if_ready, 1'b0);
        check_val({tag, "_mem_ready"}, mem_ready, 1'b0);
        check_val({tag, "_if_rdata"}, if_rdata, 32'h0);
        check_val({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            step();
            @(posedge clk); #1 apply();
        end

        found = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (m_busy && m_owner_mem && sram_req && !sram_ack) begin
                found = 1;
                break;
            end
            step();
            @(posedge clk); #1 apply();
        end
        if (!found) check_val("mem_busy_timeout", 1'b0, 1'b1);

        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk); #1;
        if_req = 0; if_flush = 0; mem_req = 0; sram_ack = 0;
        @(posedge clk); #1 check_all_zero("rst_hold");
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        sram_ack = 1'b1;
        sram_rdata = 32'hCAFEF00D;

        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            step();
            @(posedge clk); #1 apply();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
